lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 100 ++++++++++
 tb/tb_lsu.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: aligns core accesses to a 32-bit data memory, builds byte
// enables and replicated store data, and extends load data for write-back.
module lsu (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic [2:0]  core_size_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wd_i,
   output logic [31:0] core_rd_o,
   output logic        core_stall_o,
   output logic        core_misalign_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wd_o,
   input  logic [31:0] mem_rd_i,
   input  logic        mem_ready_i,
   output logic        state_o
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t      state;
   logic        is_byte;
   logic        is_half;
   logic        is_word;
   logic        is_unsigned;
   logic        misalign;
   logic        valid;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   // Reserved size codes (011, 110, 111) fall into the word case.
   always_comb begin
      is_byte     = (core_size_i[1:0] == 2'b00);
      is_half     = (core_size_i[1:0] == 2'b01);
      is_word     = !is_byte && !is_half;
      is_unsigned = core_size_i[2];
      misalign    = core_req_i &&
                    ((is_half && core_addr_i[0]) ||
                     (is_word && (core_addr_i[1:0] != 2'b00)));
      valid       = core_req_i && !misalign && !rst_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (valid) state <= BUSY;
            BUSY: if (mem_ready_i) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign state_o = state;

   // The stall drops in the cycle the memory answers, so the core samples
   // load data and advances on that same edge.
   always_comb begin
      core_stall_o    = valid && !((state == BUSY) && mem_ready_i);
      core_misalign_o = misalign && !rst_i;
      mem_req_o       = valid;
      mem_we_o        = core_we_i;
      mem_addr_o      = core_addr_i;
   end

   always_comb begin
      mem_be_o = 4'b1111;
      mem_wd_o = core_wd_i;
      if (is_byte) begin
         mem_be_o = 4'b0001 << core_addr_i[1:0];
         mem_wd_o = {4{core_wd_i[7:0]}};
      end else if (is_half) begin
         mem_be_o = core_addr_i[1] ? 4'b1100 : 4'b0011;
         mem_wd_o = {2{core_wd_i[15:0]}};
      end
   end

   always_comb begin
      case (core_addr_i[1:0])
         2'b00:   rd_byte = mem_rd_i[7:0];
         2'b01:   rd_byte = mem_rd_i[15:8];
         2'b10:   rd_byte = mem_rd_i[23:16];
         default: rd_byte = mem_rd_i[31:24];
      endcase
      rd_half = core_addr_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
      if (is_byte)
         core_rd_o = {{24{!is_unsigned && rd_byte[7]}}, rd_byte};
      else if (is_half)
         core_rd_o = {{16{!is_unsigned && rd_half[15]}}, rd_half};
      else
         core_rd_o = mem_rd_i;
   end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed scenarios plus random accesses checked against an
// arithmetic model of sizes, lanes and extension.
module tb_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        core_misalign_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;
  logic        state_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rd;
  logic [31:0] last_be;
  logic [31:0] last_wd;
  logic        last_we;
  int          stall_cycles;

  lsu dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
    .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
    .core_stall_o(core_stall_o), .core_misalign_o(core_misalign_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i),
    .mem_ready_i(mem_ready_i), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] size);
    case (size)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic m_misalign(input logic [2:0] size, input logic [31:0] addr);
    return (addr % nbytes(size)) != 0;
  endfunction

  function automatic logic [31:0] m_be(input logic [2:0] size, input logic [31:0] addr);
    int n = nbytes(size);
    return 32'(((1 << n) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] size, input logic [31:0] wd);
    int n = nbytes(size);
    if (n == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] size, input logic [31:0] addr,
                                       input logic [31:0] mrd);
    int n = nbytes(size);
    longint unsigned off = addr % 4;
    longint unsigned v;
    longint unsigned top = 64'd1 << (8 * n);
    v = (64'(mrd) >> (8 * off)) % top;
    if ((size == 3'd0 || size == 3'd1) && v >= top / 2) v = v - top;
    return v[31:0];
  endfunction

  // ---------------- driver ----------------
  task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] mrd, input int waits);
    logic mis;
    mis = m_misalign(size, addr);
    @(negedge clk_i);
    core_req_i = 1'b1; core_we_i = we; core_size_i = size;
    core_addr_i = addr; core_wd_i = wd; mem_rd_i = mrd; mem_ready_i = 1'b0;
    #1;
    check_eq("misalign", 32'(core_misalign_o), 32'(mis));
    check_eq("mem_we", 32'(mem_we_o), 32'(we));
    check_eq("mem_addr", mem_addr_o, addr);
    last_be = 32'(mem_be_o);
    last_wd = mem_wd_o;
    last_we = mem_we_o;
    stall_cycles = 0;
    if (mis) begin
      check_eq("mis_req", 32'(mem_req_o), 32'd0);
      check_eq("mis_stall", 32'(core_stall_o), 32'd0);
      @(posedge clk_i); #1;
      check_eq("mis_state", 32'(state_o), 32'd0);
    end else begin
      check_eq("req", 32'(mem_req_o), 32'd1);
      check_eq("be", 32'(mem_be_o), m_be(size, addr));
      if (we) check_eq("wd", mem_wd_o, m_wd(size, wd));
      check_eq("stall_first", 32'(core_stall_o), 32'd1);
      check_eq("state_idle", 32'(state_o), 32'd0);
      if (core_stall_o) stall_cycles++;
      for (int i = 0; i < waits; i++) begin
        @(negedge clk_i); #1;
        check_eq("stall_wait", 32'(core_stall_o), 32'd1);
        check_eq("state_busy", 32'(state_o), 32'd1);
        if (core_stall_o) stall_cycles++;
      end
      @(negedge clk_i);
      mem_ready_i = 1'b1;
      #1;
      check_eq("stall_release", 32'(core_stall_o), 32'd0);
      check_eq("state_busy_rdy", 32'(state_o), 32'd1);
      last_rd = core_rd_o;
      if (!we) check_eq("rd", core_rd_o, m_rd(size, addr, mrd));
      @(posedge clk_i); #1;
      check_eq("state_done", 32'(state_o), 32'd0);
    end
    core_req_i = 1'b0;
    mem_ready_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'b010;
    core_addr_i = 32'h100; core_wd_i = 32'h0; mem_rd_i = 32'h0; mem_ready_i = 1'b0;
    #12;
    check_eq("rst_req", 32'(mem_req_o), 32'd0);
    check_eq("rst_stall", 32'(core_stall_o), 32'd0);
    check_eq("rst_state", 32'(state_o), 32'd0);
    core_addr_i = 32'h102;
    #1;
    check_eq("rst_misalign", 32'(core_misalign_o), 32'd0);
    core_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;

    // LW aligned, 2-cycle access
    access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    check_eq("lw_be", last_be, 32'hF);
    check_eq("lw_rd", last_rd, 32'hDEADBEEF);
    check_eq("lw_stalls", 32'(stall_cycles), 32'd1);

    // Loads with extension
    access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0);
    check_eq("lb_rd", last_rd, 32'hFFFFFF80);
    access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0);
    check_eq("lbu_rd", last_rd, 32'h00000080);
    access(1'b0, 3'b101, 32'h102, 32'h0, 32'h80112233, 1);
    check_eq("lhu_rd", last_rd, 32'h00008011);

    // Stores
    access(1'b1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 0);
    check_eq("sb_be", last_be, 32'h2);
    check_eq("sb_wd", last_wd, 32'hA5A5A5A5);
    check_eq("sb_we", 32'(last_we), 32'd1);
    access(1'b1, 3'b001, 32'h202, 32'h00001234, 32'h0, 0);
    check_eq("sh_be", last_be, 32'hC);
    check_eq("sh_wd", last_wd, 32'h12341234);

    // Long wait: stall high for 4 cycles
    access(1'b0, 3'b010, 32'h300, 32'h0, 32'h01234567, 3);
    check_eq("wait_stalls", 32'(stall_cycles), 32'd4);

    // Misaligned word
    access(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0);

    // Reserved size code treated as word
    access(1'b0, 3'b111, 32'h400, 32'h0, 32'hCAFEF00D, 0);
    check_eq("rsvd_rd", last_rd, 32'hCAFEF00D);

    // Reset mid-BUSY, then a stray ready
    @(negedge clk_i);
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'b010; core_addr_i = 32'h500;
    @(posedge clk_i); #1;
    check_eq("pre_rst_busy", 32'(state_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check_eq("mid_rst_state", 32'(state_o), 32'd0);
    check_eq("mid_rst_stall", 32'(core_stall_o), 32'd0);
    check_eq("mid_rst_req", 32'(mem_req_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0; core_req_i = 1'b0; mem_ready_i = 1'b1;
    @(posedge clk_i); #1;
    check_eq("post_rst_state", 32'(state_o), 32'd0);
    check_eq("post_rst_stall", 32'(core_stall_o), 32'd0);
    check_eq("post_rst_req", 32'(mem_req_o), 32'd0);
    mem_ready_i = 1'b0;

    // Random accesses, back to back
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      access(1'(($urandom_range(0, 1))), 3'($urandom_range(0, 7)), a, $urandom, $urandom,
             $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
